iter_alu: RTL and testbench
===========================

Name: iter_alu

Overview:
- Multi-cycle execute-stage ALU sitting directly downstream of the ALU controller.
- Consumes the controller's 4-bit Operation code plus two operands.
- Produces a result word, a branch-condition flag and a zero flag through a valid/ready handshake.
- Logic/arithmetic/compare ops finish in 1 cycle; shifts iterate 1 bit per cycle to keep the barrel shifter out of the critical path.

Parameters:
- WIDTH, 32, operand/result width in bits.
- SHAMT_W, $clog2(WIDTH), shift-amount width; only srcb[SHAMT_W-1:0] is used for shifts.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous active-high reset.
- in_valid  input  1  operation/operands present.
- in_ready  output  1  block can accept an operation.
- operation  input  4  Operation code from the ALU controller.
- srca  input  WIDTH  operand A (rs1).
- srcb  input  WIDTH  operand B (rs2 or immediate).
- out_valid  output  1  result registers hold a valid result.
- out_ready  input  1  consumer accepts the result.
- result  output  WIDTH  ALU result.
- cond  output  1  branch-taken / compare flag.
- zero  output  1  result == 0.
- illegal  output  1  operation code not in the table.

Behaviour:
Operation encoding, fixed, from the controller:
- 0000 AND; 0001 OR; 0010 ADD; 0011 XOR; 0110 SUB.
- 0100 SLL; 0101 SRL; 0111 SRA.
- 1100 SLT/BLT; 1000 BEQ; 1010 BNE; 1001 BGE.
- All other codes are illegal.

Arithmetic and width rules:
- Two's complement; ADD/SUB wrap modulo 2^WIDTH with no overflow flag.
- SLT/BLT: signed A<B gives result=1 and cond=1, else 0/0.
- BEQ: cond=(A==B). BNE: cond=(A!=B). BGE: cond = signed A>=B. For all three, result=0.
- Non-compare ops: cond=0.
- SRA replicates the MSB of A; SLL/SRL fill with 0.
- Illegal code: result=0, cond=0, illegal=1; completes with 1-cycle latency (no hang).

State machine:
- States: IDLE, SHIFT, DONE. in_ready=1 only in IDLE; out_valid=1 only in DONE.
- IDLE, on in_valid:
  - Non-shift op: compute and register result/cond/illegal; next state DONE. Latency 1 (out_valid high the cycle after acceptance).
  - Shift op with shamt=0: result=srca; next state DONE.
  - Shift op with shamt>0: load accumulator=srca and counter=shamt; next state SHIFT.
- SHIFT: each cycle shift the accumulator 1 bit in the latched direction and decrement the counter. When counter reaches 1, perform the final shift, register the result and go to DONE. Total latency = shamt+1 cycles; max WIDTH cycles for shamt=WIDTH-1.
- DONE:
  - Hold result/cond/zero/illegal stable until out_ready.
  - On out_valid&&out_ready, go to IDLE. The next op can be accepted the following cycle (no same-cycle turnaround).
- Inputs are sampled only at acceptance; operand changes while in SHIFT or DONE have no effect.
- zero is combinational from the registered result (result==0).
- in_valid while not in IDLE is ignored (no accept).
- out_ready held high while not in DONE has no effect.

Reset (asynchronous, any state, including mid-shift):
- State returns to IDLE; the in-flight op is discarded.
- Output values at reset: in_ready=1, out_valid=0, result=0, cond=0, illegal=0, zero=1.
- Accumulator and counter cleared.

Decomposition:
- Shared package alu_pkg holds:
  - localparams for each Operation code (OP_AND, OP_OR, OP_ADD, OP_XOR, OP_SUB, OP_SLL, OP_SRL, OP_SRA, OP_SLT, OP_BEQ, OP_BNE, OP_BGE);
  - the state enum typedef (ST_IDLE, ST_SHIFT, ST_DONE);
  - the shift-direction typedef (SH_LEFT, SH_RIGHT_LOG, SH_RIGHT_ARITH).
- One natural sub-module: iter_shifter, which owns the accumulator, counter and direction register.
  - Inputs: load/shamt/dir/data.
  - Outputs: data and last (asserted on the final-shift cycle).
- The FSM and single-cycle datapath stay in iter_alu.

Test Plan:
- ADD/SUB: op 0010, A=0x7FFFFFFF, B=1 -> result 0x80000000 one cycle after accept, zero=0. Then op 0110, A=5, B=5 -> result 0, zero=1.
- Compares: op 1100, A=0xFFFFFFFF, B=1 -> result 1, cond 1. Op 1001, same operands -> cond 0, result 0. Op 1000, A=B=0x1234 -> cond 1. Op 1010, same operands -> cond 0.
- Shifts:
  - op 0111, A=0x80000000, B=31 -> result 0xFFFFFFFF, out_valid exactly 32 cycles after accept.
  - op 0101, same operands -> 0x00000001.
  - op 0100, A=1, B=0 -> result 1 after 1 cycle.
- Backpressure: complete op 0011, A=0xF0F0F0F0, B=0xFFFF0000 with out_ready=0 for 5 cycles -> result 0x0F0FF0F0 held stable, in_ready=0, extra in_valid ignored. Accepted on out_ready; next op accepted the following cycle.
- Reset mid-shift: start op 0100, B=20; assert reset at cycle 7 -> out_valid=0, in_ready=1 immediately. A subsequent op 0001, A=0xA, B=0x5 -> result 0xF.
- Illegal code: op 1111 -> out_valid after 1 cycle, illegal=1, result=0, cond=0; the next legal op clears illegal.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the iterative execute-stage ALU: operation codes,
// FSM states and shift directions.
package alu_pkg;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_XOR = 4'b0011;
    localparam logic [3:0] OP_SLL = 4'b0100;
    localparam logic [3:0] OP_SRL = 4'b0101;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SRA = 4'b0111;
    localparam logic [3:0] OP_BEQ = 4'b1000;
    localparam logic [3:0] OP_BGE = 4'b1001;
    localparam logic [3:0] OP_BNE = 4'b1010;
    localparam logic [3:0] OP_SLT = 4'b1100;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } state_e;

    typedef enum logic [1:0] {
        SH_LEFT,
        SH_RIGHT_LOG,
        SH_RIGHT_ARITH
    } shdir_e;

    function automatic logic is_shift(input logic [3:0] op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

endpackage

// File: rtl/iter_shifter.sv
// One-bit-per-cycle shifter: holds the accumulator, remaining count and
// latched direction; data_out is the accumulator after this cycle's shift.
module iter_shifter
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [SHAMT_W-1:0] shamt,
    input  shdir_e             dir,
    input  logic [WIDTH-1:0]   data_in,
    output logic [WIDTH-1:0]   data_out,
    output logic               last
);

    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    shdir_e             dir_q, dir_d;
    logic [WIDTH-1:0]   acc_shift;

    always_comb begin
        acc_shift = acc_q;
        case (dir_q)
            SH_LEFT:        acc_shift = {acc_q[WIDTH-2:0], 1'b0};
            SH_RIGHT_LOG:   acc_shift = {1'b0, acc_q[WIDTH-1:1]};
            SH_RIGHT_ARITH: acc_shift = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
            default:        acc_shift = acc_q;
        endcase
    end

    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        dir_d = dir_q;
        if (load) begin
            acc_d = data_in;
            cnt_d = shamt;
            dir_d = dir;
        end else if (cnt_q != '0) begin
            acc_d = acc_shift;
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q <= '0;
            cnt_q <= '0;
            dir_q <= SH_LEFT;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            dir_q <= dir_d;
        end
    end

    assign data_out = acc_shift;
    // The owner registers data_out on this cycle to capture the final shift.
    assign last     = (cnt_q == {{(SHAMT_W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/iter_alu.sv
// Multi-cycle execute ALU: single-cycle logic/arith/compare, iterative shifts,
// result presented through a valid/ready handshake.
module iter_alu
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       operation,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cond,
    output logic             zero,
    output logic             illegal
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             cond_q, cond_d;
    logic             illegal_q, illegal_d;

    logic [WIDTH-1:0] alu_res;
    logic             alu_cond;
    logic             alu_ill;
    shdir_e           sh_dir;
    logic             sh_load;
    logic [WIDTH-1:0] sh_data;
    logic             sh_last;
    logic [SHAMT_W-1:0] shamt;

    assign shamt = srcb[SHAMT_W-1:0];

    always_comb begin
        alu_res  = '0;
        alu_cond = 1'b0;
        alu_ill  = 1'b0;
        case (operation)
            OP_AND: alu_res = srca & srcb;
            OP_OR:  alu_res = srca | srcb;
            OP_XOR: alu_res = srca ^ srcb;
            OP_ADD: alu_res = srca + srcb;
            OP_SUB: alu_res = srca - srcb;
            OP_SLT: begin
                alu_cond = $signed(srca) < $signed(srcb);
                alu_res  = {{(WIDTH-1){1'b0}}, alu_cond};
            end
            OP_BEQ: alu_cond = (srca == srcb);
            OP_BNE: alu_cond = (srca != srcb);
            OP_BGE: alu_cond = $signed(srca) >= $signed(srcb);
            OP_SLL, OP_SRL, OP_SRA: alu_ill = 1'b0;
            default: alu_ill = 1'b1;
        endcase
    end

    always_comb begin
        case (operation)
            OP_SLL:  sh_dir = SH_LEFT;
            OP_SRL:  sh_dir = SH_RIGHT_LOG;
            default: sh_dir = SH_RIGHT_ARITH;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        cond_d    = cond_q;
        illegal_d = illegal_q;
        sh_load   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    if (is_shift(operation)) begin
                        cond_d    = 1'b0;
                        illegal_d = 1'b0;
                        if (shamt == '0) begin
                            result_d = srca;
                            state_d  = ST_DONE;
                        end else begin
                            sh_load = 1'b1;
                            state_d = ST_SHIFT;
                        end
                    end else begin
                        result_d  = alu_res;
                        cond_d    = alu_cond;
                        illegal_d = alu_ill;
                        state_d   = ST_DONE;
                    end
                end
            end
            ST_SHIFT: begin
                if (sh_last) begin
                    result_d = sh_data;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            result_q  <= '0;
            cond_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            cond_q    <= cond_d;
            illegal_q <= illegal_d;
        end
    end

    iter_shifter #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) u_shifter (
        .clk      (clk),
        .reset    (reset),
        .load     (sh_load),
        .shamt    (shamt),
        .dir      (sh_dir),
        .data_in  (srca),
        .data_out (sh_data),
        .last     (sh_last)
    );

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign result    = result_q;
    assign cond      = cond_q;
    assign illegal   = illegal_q;
    assign zero      = (result_q == '0);

endmodule

// File: tb/tb_iter_alu.sv
// Directed bench for iter_alu: hand-computed vectors, latency and handshake checks.
module tb_iter_alu;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  operation = 4'h0;
    logic [31:0] srca = '0;
    logic [31:0] srcb = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        cond;
    logic        zero;
    logic        illegal;

    int n_tests = 0;
    int n_fail  = 0;
    int lat;

    always #5 clk = ~clk;

    iter_alu #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .operation (operation),
        .srca      (srca),
        .srcb      (srcb),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cond      (cond),
        .zero      (zero),
        .illegal   (illegal)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one op at the next edge, then wait (bounded) for out_valid.
    // lat counts edges from the accepting edge through the one raising out_valid.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int l);
        operation = op;
        srca      = a;
        srcb      = b;
        in_valid  = 1'b1;
        tick();
        in_valid  = 1'b0;
        srca      = 32'hDEAD_BEEF;
        srcb      = 32'h0000_0003;
        l = 1;
        while (!out_valid && l < 100) begin
            tick();
            l++;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_result", result, 32'h0);
        chk("rst_cond_ill", {30'b0, cond, illegal}, 32'd0);
        chk("rst_zero", {31'b0, zero}, 32'd1);
        reset = 1'b0;
        tick();

        run_op(4'b0010, 32'h7FFF_FFFF, 32'h1, lat);
        chk("add_lat", lat, 32'd1);
        chk("add_res", result, 32'h8000_0000);
        chk("add_zero", {31'b0, zero}, 32'd0);
        chk("add_ready", {31'b0, in_ready}, 32'd0);
        consume();
        chk("idle_ready", {31'b0, in_ready}, 32'd1);

        run_op(4'b0110, 32'd5, 32'd5, lat);
        chk("sub_res", result, 32'h0);
        chk("sub_zero", {31'b0, zero}, 32'd1);
        consume();

        run_op(4'b1100, 32'hFFFF_FFFF, 32'h1, lat);
        chk("slt_res", result, 32'd1);
        chk("slt_cond", {31'b0, cond}, 32'd1);
        consume();
        run_op(4'b1001, 32'hFFFF_FFFF, 32'h1, lat);
        chk("bge_cond", {31'b0, cond}, 32'd0);
        chk("bge_res", result, 32'd0);
        consume();
        run_op(4'b1000, 32'h1234, 32'h1234, lat);
        chk("beq_cond", {31'b0, cond}, 32'd1);
        chk("beq_res", result, 32'd0);
        consume();
        run_op(4'b1010, 32'h1234, 32'h1234, lat);
        chk("bne_cond", {31'b0, cond}, 32'd0);
        consume();

        run_op(4'b0111, 32'h8000_0000, 32'd31, lat);
        chk("sra_lat", lat, 32'd32);
        chk("sra_res", result, 32'hFFFF_FFFF);
        chk("sra_cond", {31'b0, cond}, 32'd0);
        consume();
        run_op(4'b0101, 32'h8000_0000, 32'd31, lat);
        chk("srl_lat", lat, 32'd32);
        chk("srl_res", result, 32'h0000_0001);
        consume();
        run_op(4'b0100, 32'h1, 32'd0, lat);
        chk("sll0_lat", lat, 32'd1);
        chk("sll0_res", result, 32'h1);
        consume();
        run_op(4'b0100, 32'h3, 32'd4, lat);
        chk("sll4_lat", lat, 32'd5);
        chk("sll4_res", result, 32'h30);
        consume();

        // Backpressure: result held, stray in_valid ignored.
        run_op(4'b0011, 32'hF0F0_F0F0, 32'hFFFF_0000, lat);
        operation = 4'b0001;
        srca      = 32'h1;
        srcb      = 32'h2;
        in_valid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_res", result, 32'h0F0F_F0F0);
            chk("bp_valid", {31'b0, out_valid}, 32'd1);
            chk("bp_ready", {31'b0, in_ready}, 32'd0);
            tick();
        end
        in_valid = 1'b0;
        chk("bp_res_end", result, 32'h0F0F_F0F0);
        consume();
        chk("bp_idle", {31'b0, in_ready}, 32'd1);
        run_op(4'b0000, 32'hFF00, 32'h0FF0, lat);
        chk("bp_next_lat", lat, 32'd1);
        chk("bp_next_res", result, 32'h0F00);
        consume();

        // Reset in the middle of a 20-step shift.
        operation = 4'b0100;
        srca      = 32'h1;
        srcb      = 32'd20;
        in_valid  = 1'b1;
        tick();
        in_valid  = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        chk("mid_busy", {30'b0, in_ready, out_valid}, 32'd0);
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", {31'b0, out_valid}, 32'd0);
        chk("mid_rst_ready", {31'b0, in_ready}, 32'd1);
        chk("mid_rst_zero", {31'b0, zero}, 32'd1);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 25; i++) begin
            if (out_valid) chk("mid_stale_valid", {31'b0, out_valid}, 32'd0);
            tick();
        end
        run_op(4'b0001, 32'hA, 32'h5, lat);
        chk("or_lat", lat, 32'd1);
        chk("or_res", result, 32'hF);
        consume();

        run_op(4'b1111, 32'h55, 32'h55, lat);
        chk("ill_lat", lat, 32'd1);
        chk("ill_flag", {31'b0, illegal}, 32'd1);
        chk("ill_res", result, 32'h0);
        chk("ill_cond", {31'b0, cond}, 32'd0);
        consume();
        run_op(4'b0010, 32'h1, 32'h2, lat);
        chk("ill_clear", {31'b0, illegal}, 32'd0);
        chk("ill_next_res", result, 32'h3);
        consume();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
